// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared types and constants for the block-RAM port arbiter.
//   state_e    : arbiter FSM states (3-bit encoding)
//   gnt_e      : grant-select encoding used at IDLE arbitration
//   WAIT_CNT_W : width of the video starvation counter
// Optional feature macro used by the arbiter: MEM_PORT_ARBITER_STARVE_GUARD_EN
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ACC_CPU  = 3'd1,
        ACC_VID  = 3'd2,
        DONE_CPU = 3'd3,
        DONE_VID = 3'd4
    } state_e;

    typedef enum logic {
        GNT_CPU = 1'b0,
        GNT_VID = 1'b1
    } gnt_e;

    localparam int WAIT_CNT_W = 4;
    localparam logic [WAIT_CNT_W-1:0] WAIT_CNT_MAX = {WAIT_CNT_W{1'b1}};

endpackage

// File: rtl/mem_port_arbiter_starve_ctr.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_starve_ctr
// Saturating count of arbitrations the video requester has lost, with clear
// and a threshold compare. Only instantiated when
// MEM_PORT_ARBITER_STARVE_GUARD_EN is defined.
// Ports:
//   clk    : system clock
//   reset  : synchronous active-high reset (counter -> 0)
//   clr_i  : clear the counter (has priority over inc_i)
//   inc_i  : add one, saturating at WAIT_CNT_MAX
//   hit_o  : counter >= MAX_WAIT
// -----------------------------------------------------------------------------
module mem_port_arbiter_starve_ctr
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic inc_i,
    output logic hit_o
);

    logic [WAIT_CNT_W-1:0] cnt_q;
    logic [WAIT_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != WAIT_CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit_o = (int'(cnt_q) >= MAX_WAIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one synchronous block-RAM port between the CPU (read/write) and the
// video scan-out (read-only). Each access occupies the port for 3 cycles:
// IDLE (arbitrate) -> ACC_x (mem_en pulse) -> DONE_x (ack + read data).
// CPU has fixed priority. With MEM_PORT_ARBITER_STARVE_GUARD_EN defined, video
// wins arbitration once it has lost MAX_WAIT times in a row.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   cpu_req/we/addr/wdata      : CPU request, held until cpu_ack
//   cpu_ack, cpu_rdata         : one-cycle completion, read data during ack
//   vid_req/addr               : video read request, held until vid_ack
//   vid_ack, vid_rdata         : one-cycle completion, read data during ack
//   mem_en/we/addr/wdata       : registered RAM port controls
//   mem_rdata                  : RAM read data (valid cycle after read enable)
//   busy                       : FSM is not in IDLE
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    output logic [DATA_W-1:0] vid_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    // Reject an out-of-range threshold at elaboration time.
    generate
        if ((MAX_WAIT < 1) || (MAX_WAIT > 15)) begin : g_bad_max_wait
            $error("mem_port_arbiter: MAX_WAIT must be in 1..15");
        end
    endgenerate

    state_e            state_q, state_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    gnt_e              gnt;
    logic              vid_force;

`ifdef MEM_PORT_ARBITER_STARVE_GUARD_EN
    logic arb_idle;
    logic ctr_inc;
    logic ctr_clr;

    // Count only arbitrations video actually lost to the CPU; clear when
    // video is granted (entry into ACC_VID).
    assign arb_idle = (state_q == IDLE);
    assign ctr_inc  = arb_idle && vid_req && cpu_req && (gnt == GNT_CPU);
    assign ctr_clr  = arb_idle && vid_req && (gnt == GNT_VID);

    mem_port_arbiter_starve_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve_ctr (
        .clk   (clk),
        .reset (reset),
        .clr_i (ctr_clr),
        .inc_i (ctr_inc),
        .hit_o (vid_force)
    );
`else
    assign vid_force = 1'b0;
`endif

    // Grant select: video only when CPU is idle, or when the guard forces it.
    always_comb begin
        gnt = GNT_CPU;
        if (vid_req && (!cpu_req || vid_force)) begin
            gnt = GNT_VID;
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            IDLE: begin
                if (cpu_req || vid_req) begin
                    mem_en_d = 1'b1;
                    if (gnt == GNT_VID) begin
                        state_d     = ACC_VID;
                        mem_addr_d  = vid_addr;
                        mem_wdata_d = '0;
                    end else begin
                        state_d     = ACC_CPU;
                        mem_we_d    = cpu_we;
                        mem_addr_d  = cpu_addr;
                        mem_wdata_d = cpu_wdata;
                    end
                end
            end
            ACC_CPU:  state_d = DONE_CPU;
            ACC_VID:  state_d = DONE_VID;
            DONE_CPU: state_d = IDLE;
            DONE_VID: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    // RAM read data arrives in the DONE cycle; it is passed straight through.
    assign cpu_ack   = (state_q == DONE_CPU);
    assign vid_ack   = (state_q == DONE_VID);
    assign cpu_rdata = mem_rdata;
    assign vid_rdata = mem_rdata;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter with a registered-read RAM model.
// Cycle c is the interval after the c-th rising edge; inputs are driven and
// outputs sampled 1 time unit after that edge.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              cpu_req, cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic              vid_ack;
    logic [DATA_W-1:0] vid_rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    // RAM model with a backdoor preload port (single writer process)
    logic [DATA_W-1:0] ram [0:65535];
    logic              bd_we = 1'b0;
    logic [ADDR_W-1:0] bd_addr = '0;
    logic [DATA_W-1:0] bd_data = '0;

    int n_cmp = 0;
    int n_bad = 0;
    int cpu_ack_total = 0;
    int vid_ack_total = 0;
    int ack_rule_viol = 0;
    logic prev_ack = 1'b0;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .vid_req   (vid_req),
        .vid_addr  (vid_addr),
        .vid_ack   (vid_ack),
        .vid_rdata (vid_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always @(posedge clk) begin
        if (bd_we) begin
            ram[bd_addr] <= bd_data;
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    // Ack monitor: never both at once, never two consecutive ack cycles.
    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            if (cpu_ack === 1'b1) cpu_ack_total++;
            if (vid_ack === 1'b1) vid_ack_total++;
            if (cpu_ack === 1'b1 && vid_ack === 1'b1) ack_rule_viol++;
            if ((cpu_ack === 1'b1 || vid_ack === 1'b1) && prev_ack) ack_rule_viol++;
            prev_ack = (cpu_ack === 1'b1 || vid_ack === 1'b1);
        end else begin
            prev_ack = 1'b0;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bd_addr = a;
        bd_data = d;
        bd_we   = 1'b1;
        next_cycle();
        bd_we   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        vid_req = 1'b0; vid_addr = '0;
        next_cycle();
        preload(16'h0040, 16'hBEEF);
        preload(16'h2000, 16'h00FF);
        reset = 1'b0;
        next_cycle();
        n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
        n_cmp++; if (mem_en !== 1'b0)   begin n_bad++; $display("FAIL reset_mem_en: got %0b want 0", mem_en); end
        n_cmp++; if (mem_we !== 1'b0)   begin n_bad++; $display("FAIL reset_mem_we: got %0b want 0", mem_we); end
        n_cmp++; if (mem_addr !== 16'h0)  begin n_bad++; $display("FAIL reset_mem_addr: got %h want 0000", mem_addr); end
        n_cmp++; if (mem_wdata !== 16'h0) begin n_bad++; $display("FAIL reset_mem_wdata: got %h want 0000", mem_wdata); end
        n_cmp++; if (cpu_ack !== 1'b0)  begin n_bad++; $display("FAIL reset_cpu_ack: got %0b want 0", cpu_ack); end
        n_cmp++; if (vid_ack !== 1'b0)  begin n_bad++; $display("FAIL reset_vid_ack: got %0b want 0", vid_ack); end
        $display("reset released, outputs idle");
    endtask

    task automatic test_cpu_read();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0040;      // cycle 0
        next_cycle();                                             // cycle 1
        n_cmp++; if (mem_en !== 1'b1)       begin n_bad++; $display("FAIL rd_mem_en: got %0b want 1", mem_en); end
        n_cmp++; if (mem_addr !== 16'h0040) begin n_bad++; $display("FAIL rd_mem_addr: got %h want 0040", mem_addr); end
        n_cmp++; if (cpu_ack !== 1'b0)      begin n_bad++; $display("FAIL rd_early_ack: got %0b want 0", cpu_ack); end
        next_cycle();                                             // cycle 2
        n_cmp++; if (cpu_ack !== 1'b1)      begin n_bad++; $display("FAIL rd_ack: got %0b want 1", cpu_ack); end
        n_cmp++; if (cpu_rdata !== 16'hBEEF) begin n_bad++; $display("FAIL rd_data: got %h want beef", cpu_rdata); end
        n_cmp++; if (mem_en !== 1'b0)       begin n_bad++; $display("FAIL rd_mem_en_drop: got %0b want 0", mem_en); end
        cpu_req = 1'b0;
        next_cycle();                                             // cycle 3
        n_cmp++; if (busy !== 1'b0)         begin n_bad++; $display("FAIL rd_busy_end: got %0b want 0", busy); end
        $display("cpu read  addr=0040 data=%h", cpu_rdata);
    endtask

    task automatic test_write_readback();
        int vid_before;
        vid_before = vid_ack_total;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0100; cpu_wdata = 16'h1234;
        next_cycle();                                             // cycle 1
        n_cmp++; if (mem_we !== 1'b1)        begin n_bad++; $display("FAIL wr_mem_we: got %0b want 1", mem_we); end
        n_cmp++; if (mem_wdata !== 16'h1234) begin n_bad++; $display("FAIL wr_mem_wdata: got %h want 1234", mem_wdata); end
        next_cycle();                                             // cycle 2
        n_cmp++; if (cpu_ack !== 1'b1)       begin n_bad++; $display("FAIL wr_ack: got %0b want 1", cpu_ack); end
        n_cmp++; if (mem_we !== 1'b0)        begin n_bad++; $display("FAIL wr_mem_we_drop: got %0b want 0", mem_we); end
        cpu_req = 1'b0; cpu_we = 1'b0;
        $display("cpu write addr=0100 data=1234");
        next_cycle();
        cpu_req = 1'b1; cpu_addr = 16'h0100;
        next_cycle();
        next_cycle();
        n_cmp++; if (cpu_ack !== 1'b1)       begin n_bad++; $display("FAIL rb_ack: got %0b want 1", cpu_ack); end
        n_cmp++; if (cpu_rdata !== 16'h1234) begin n_bad++; $display("FAIL rb_data: got %h want 1234", cpu_rdata); end
        cpu_req = 1'b0;
        next_cycle();
        n_cmp++; if (vid_ack_total !== vid_before) begin n_bad++; $display("FAIL wr_no_vid_ack: got %0d vid acks want 0", vid_ack_total - vid_before); end
        $display("cpu read  addr=0100 data=%h", cpu_rdata);
    endtask

    task automatic test_back_to_back();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0040;      // cycle 0
        next_cycle(); next_cycle();                               // cycle 2
        n_cmp++; if (cpu_rdata !== 16'hBEEF || cpu_ack !== 1'b1) begin n_bad++; $display("FAIL b2b_first: ack=%0b data=%h want 1/beef", cpu_ack, cpu_rdata); end
        cpu_addr = 16'h0100;                                      // req held: new request
        next_cycle();                                             // cycle 3
        n_cmp++; if (cpu_ack !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL b2b_gap: ack=%0b busy=%0b want 0/0", cpu_ack, busy); end
        next_cycle();                                             // cycle 4
        n_cmp++; if (mem_addr !== 16'h0100 || mem_en !== 1'b1) begin n_bad++; $display("FAIL b2b_issue: addr=%h en=%0b want 0100/1", mem_addr, mem_en); end
        next_cycle();                                             // cycle 5
        n_cmp++; if (cpu_ack !== 1'b1 || cpu_rdata !== 16'h1234) begin n_bad++; $display("FAIL b2b_second: ack=%0b data=%h want 1/1234", cpu_ack, cpu_rdata); end
        cpu_req = 1'b0;
        next_cycle();
        $display("cpu back-to-back reads 0040, 0100 done");
    endtask

    task automatic test_idle_video();
        vid_req = 1'b1; vid_addr = 16'h2000;                      // cycle 0
        next_cycle();                                             // cycle 1
        n_cmp++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h2000) begin n_bad++; $display("FAIL vid_issue: en=%0b we=%0b addr=%h want 1/0/2000", mem_en, mem_we, mem_addr); end
        next_cycle();                                             // cycle 2
        n_cmp++; if (vid_ack !== 1'b1)       begin n_bad++; $display("FAIL vid_ack: got %0b want 1", vid_ack); end
        n_cmp++; if (vid_rdata !== 16'h00FF) begin n_bad++; $display("FAIL vid_data: got %h want 00ff", vid_rdata); end
        n_cmp++; if (cpu_ack !== 1'b0 || mem_we !== 1'b0) begin n_bad++; $display("FAIL vid_side: cpu_ack=%0b mem_we=%0b want 0/0", cpu_ack, mem_we); end
        vid_req = 1'b0;
        next_cycle();
        $display("vid read  addr=2000 data=%h", vid_rdata);
    endtask

    task automatic test_contention();
        int cn, vn, first_vid;
        int exp_cn, exp_vn, exp_first;
`ifdef MEM_PORT_ARBITER_STARVE_GUARD_EN
        exp_cn = 8;  exp_vn = 2; exp_first = 14;
`else
        exp_cn = 10; exp_vn = 0; exp_first = -1;
`endif
        cn = 0; vn = 0; first_vid = -1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0040;
        vid_req = 1'b1; vid_addr = 16'h2000;
        for (int c = 0; c < 30; c++) begin
            if (cpu_ack === 1'b1) cn++;
            if (vid_ack === 1'b1) begin
                vn++;
                if (first_vid < 0) first_vid = c;
            end
            next_cycle();
        end
        cpu_req = 1'b0; vid_req = 1'b0;
        next_cycle();
        n_cmp++; if (cn != exp_cn) begin n_bad++; $display("FAIL cont_cpu_acks: got %0d want %0d", cn, exp_cn); end
        n_cmp++; if (vn != exp_vn) begin n_bad++; $display("FAIL cont_vid_acks: got %0d want %0d", vn, exp_vn); end
        n_cmp++; if (first_vid != exp_first) begin n_bad++; $display("FAIL cont_first_vid: got cycle %0d want %0d", first_vid, exp_first); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL cont_busy_end: got %0b want 0", busy); end
        $display("contention 30 cycles: cpu_acks=%0d vid_acks=%0d first_vid=%0d", cn, vn, first_vid);
    endtask

    task automatic test_reset_mid_access();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0040;      // cycle 0
        next_cycle();                                             // cycle 1: ACC_CPU
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rst_mid_busy: got %0b want 1", busy); end
        reset = 1'b1;
        next_cycle();                                             // cycle 2
        n_cmp++; if (busy !== 1'b0 || mem_en !== 1'b0 || cpu_ack !== 1'b0) begin n_bad++; $display("FAIL rst_mid_state: busy=%0b en=%0b ack=%0b want 0/0/0", busy, mem_en, cpu_ack); end
        n_cmp++; if (mem_addr !== 16'h0000) begin n_bad++; $display("FAIL rst_mid_addr: got %h want 0000", mem_addr); end
        reset = 1'b0;
        next_cycle();                                             // cycle 3
        n_cmp++; if (mem_en !== 1'b1 || cpu_ack !== 1'b0) begin n_bad++; $display("FAIL rst_reissue: en=%0b ack=%0b want 1/0", mem_en, cpu_ack); end
        next_cycle();                                             // cycle 4
        n_cmp++; if (cpu_ack !== 1'b1 || cpu_rdata !== 16'hBEEF) begin n_bad++; $display("FAIL rst_reissue_ack: ack=%0b data=%h want 1/beef", cpu_ack, cpu_rdata); end
        cpu_req = 1'b0;
        next_cycle();
        $display("cpu read after mid-access reset data=%h", cpu_rdata);
    endtask

    task automatic test_ack_rules();
        n_cmp++; if (ack_rule_viol != 0) begin n_bad++; $display("FAIL ack_rules: got %0d violations want 0", ack_rule_viol); end
        n_cmp++; if (cpu_ack_total == 0) begin n_bad++; $display("FAIL ack_seen: got 0 cpu acks want >0"); end
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_write_readback();
        test_back_to_back();
        test_idle_video();
        test_contention();
        test_reset_mid_access();
        test_ack_rules();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
